aurora_scan_session_ctrl: RTL and testbench
===========================================

# aurora_scan_session_ctrl

Aurora-domain end of the PMT scan start/stop handshake. It consumes the synchronized scan-start level and gates ADC samples into framed packets for the Aurora TX stream: header, fixed-length data packets, padding and a tail word. When the scan closes it returns a stretched `adc_end_o` pulse to the logic clock domain through a pulse CDC, which clears the real-scan flag there. It sits between the start-level CDC output and the Aurora TX user interface.

## Interface
- `TCQ`, 0.1: simulation clock-to-Q delay on all register assignments.
- `DATA_W`, 32: sample and TX word width; must be ≥ 24.
- `PKT_LEN`, 256: data words per packet, including padding; range 2..65535.
- `PAD_WORD`, 32'h0000_0000: fill value used to complete a partial packet.
- `END_PULSE_CYC`, 4: length of the `adc_end_o` high time, in cycles; range 2..15.

Ports:
- `aurora_clk_i` in 1: the only clock.
- `rst_i` in 1: synchronous, active-high reset.
- `adc_start_i` in 1: scan-start level, already synchronized to `aurora_clk_i`.
- `adc_data_i` in DATA_W: ADC sample.
- `adc_valid_i` in 1: sample strobe. There is no backpressure toward the ADC.
- `tx_data_o` out DATA_W: stream data.
- `tx_valid_o` out 1: stream valid.
- `tx_ready_i` in 1: stream ready.
- `tx_last_o` out 1: marks the last word of each packet and of the tail.
- `adc_end_o` out 1: end pulse toward the pulse CDC.
- `scan_active_o` out 1: high in every state except IDLE and END.
- `scan_id_o` out 16: current scan identifier.
- `drop_cnt_o` out 16: dropped-sample count.

## Operation
- **Start detection**
  - `start_d` registers `adc_start_i` every cycle.
  - Rising edge = `adc_start_i & ~start_d`.
  - A rising edge is acted on only in IDLE; edges seen in any other state are discarded.
- **FSM states:** IDLE, HEAD, DATA, DRAIN, PAD, TAIL, END.
- **IDLE:** on a rising edge, go to HEAD.
- **HEAD**
  - Present the header word: bits [DATA_W-1:DATA_W-8] = 8'hA5, bits [15:0] = `scan_id_o`, all other bits 0. `tx_last_o` = 0.
  - On handshake: go to DATA and clear the word count and packet count.
- **DATA**
  - Uses a 1-entry holding register `hold`.
  - A sample is loaded when `adc_valid_i & (~hold_v | tx_ready_i)`.
  - Otherwise a valid sample is dropped and `drop_cnt` increments, saturating at 16'hFFFF.
  - `tx_valid_o` = `hold_v`.
  - On each handshake, the word count increments. On word `PKT_LEN-1`, `tx_last_o` = 1, the word count wraps to 0 and the packet count increments (16-bit, wrapping).
  - When `adc_start_i` = 0, go to DRAIN.
- **DRAIN**
  - Loading is disabled; samples are ignored and not counted as drops.
  - Once `hold_v` = 0: go to TAIL if the word count = 0, otherwise go to PAD.
- **PAD:** present `PAD_WORD` until the word that completes the packet (which has `tx_last_o` = 1) is accepted, then go to TAIL.
- **TAIL**
  - Present the tail word: bits [DATA_W-1:DATA_W-8] = 8'h5A, bits [15:0] = packet count (counting the padded packet), `tx_last_o` = 1.
  - On handshake: `scan_id` increments (wrapping) and the FSM goes to END.
- **END:** `adc_end_o` = 1 for exactly `END_PULSE_CYC` cycles, then go to IDLE.
- `tx_data_o` and `tx_last_o` hold steady while `tx_valid_o` = 1 and `tx_ready_i` = 0.

## Timing
- **Reset values:**
  - FSM = IDLE.
  - All outputs 0: `tx_data_o`, `tx_valid_o`, `tx_last_o`, `adc_end_o`, `scan_active_o`.
  - `scan_id_o` = 0, `drop_cnt_o` = 0.
  - `hold_v` = 0, `start_d` = 0.
- **Reset mid-scan:** returns immediately to IDLE with no tail and no `adc_end_o`.
- **Start latency:** a rising edge at cycle N gives HEAD with `tx_valid_o` = 1 at N+1.
- **Sample latency:** a sample accepted at cycle N appears on `tx_data_o` at N+1.
- **Simultaneous events:**
  - `adc_start_i` falls in the same cycle as a sample arrives in DATA: the sample is still loaded, and the FSM enters DRAIN.
  - A drop and a handshake in the same cycle are both counted.
- **Short scan:** if `adc_start_i` falls while in HEAD, the header is still sent, then DATA → DRAIN → TAIL with packet count 0.
- **Back-to-back scans:**
  - `adc_end_o` is followed by at least 1 IDLE cycle.
  - A new rising edge is required to start again; a level held high through END does not restart.
- **Pulse CDC rule:** the `adc_end_o` high time and gap are each ≥ 2 cycles, which satisfies the pulse-CDC minimum when `aurora_clk_i` is the slower clock.

## Configuration
- Macro: `SCAN_DROP_CNT_EN`.
- **Defined:** `drop_cnt` is implemented as above and clears on the HEAD handshake.
- **Undefined:**
  - `drop_cnt_o` is tied to 0.
  - Drops still occur silently.
  - All other behaviour is identical.

## Test plan
- **Exact packet:** PKT_LEN=4, scan of 8 samples with `tx_ready_i`=1 → stream is A5 header with id 0, samples 0..7 with `tx_last_o` on the 4th and 8th words, then tail 5A…0002; `adc_end_o` high for 4 cycles; `scan_id_o` = 1.
- **Partial packet:** PKT_LEN=4, scan of 5 samples → samples 0..4, then 3 `PAD_WORD`s with `tx_last_o` on the last pad, then tail with packet count 2.
- **Backpressure:** `tx_ready_i` low for 3 cycles while a sample arrives every cycle → with the macro defined, `drop_cnt_o` = 2 and the held word stays stable; with it undefined, `drop_cnt_o` = 0.
- **Empty scan:** a 1-cycle `adc_start_i` pulse → header, then tail with count 0, then `adc_end_o`.
- **Reset mid-DATA:** `rst_i` asserted after 2 samples → all outputs 0 the next cycle, and no `adc_end_o`.
- **Held start:** `adc_start_i` held high through END → FSM returns to IDLE and stays there until `adc_start_i` goes low and then high again.

Source files
------------

// File: rtl/aurora_scan_session_ctrl.sv
// aurora_scan_session_ctrl: Aurora-side scan session framer. Turns the scan-start
//   level into a framed TX stream (header, fixed-length data packets, padding,
//   tail) and returns a stretched adc_end_o pulse for the pulse CDC.
// Ports: aurora_clk_i/rst_i (sync, active-high); adc_start_i/adc_data_i/adc_valid_i
//   from the ADC side (no backpressure); tx_data_o/tx_valid_o/tx_ready_i/tx_last_o
//   toward Aurora TX; adc_end_o, scan_active_o, scan_id_o, drop_cnt_o status.
// Optional feature macro: SCAN_DROP_CNT_EN (dropped-sample counter; 0 when undefined).
module aurora_scan_session_ctrl #(
  parameter real               TCQ           = 0.1,
  parameter int                DATA_W        = 32,
  parameter int                PKT_LEN       = 256,
  parameter logic [DATA_W-1:0] PAD_WORD      = '0,
  parameter int                END_PULSE_CYC = 4
) (
  input  logic              aurora_clk_i,
  input  logic              rst_i,
  input  logic              adc_start_i,
  input  logic [DATA_W-1:0] adc_data_i,
  input  logic              adc_valid_i,
  output logic [DATA_W-1:0] tx_data_o,
  output logic              tx_valid_o,
  input  logic              tx_ready_i,
  output logic              tx_last_o,
  output logic              adc_end_o,
  output logic              scan_active_o,
  output logic [15:0]       scan_id_o,
  output logic [15:0]       drop_cnt_o
);

  // TCQ only models clock-to-Q in behavioural sims; the synthesizable registers
  // carry no delay, so it is only range-checked here.
  if (DATA_W < 24 || PKT_LEN < 2 || PKT_LEN > 65535 ||
      END_PULSE_CYC < 2 || END_PULSE_CYC > 15 || TCQ < 0.0) begin : g_bad_param
    $error("aurora_scan_session_ctrl: parameter out of range");
  end

  localparam logic [15:0] LAST_IDX = 16'(PKT_LEN - 1);
  localparam logic [3:0]  END_LAST = 4'(END_PULSE_CYC - 1);

  typedef enum logic [2:0] {
    S_IDLE, S_HEAD, S_DATA, S_DRAIN, S_PAD, S_TAIL, S_END
  } state_t;

  state_t            state, next_state;
  logic              start_d;
  logic              rise;
  logic [DATA_W-1:0] hold;
  logic              hold_v;
  logic [15:0]       word_cnt;
  logic [15:0]       pkt_cnt;
  logic [15:0]       scan_id;
  logic [3:0]        end_cnt;
  logic              load;
  logic              hs;
  logic              pkt_done;
  logic [DATA_W-1:0] hdr_word;
  logic [DATA_W-1:0] tail_word;

  assign rise     = adc_start_i & ~start_d;
  assign pkt_done = (word_cnt == LAST_IDX);
  assign hs       = tx_valid_o & tx_ready_i;

  always_comb begin
    hdr_word                   = '0;
    hdr_word[DATA_W-1 -: 8]    = 8'hA5;
    hdr_word[15:0]             = scan_id;
    tail_word                  = '0;
    tail_word[DATA_W-1 -: 8]   = 8'h5A;
    tail_word[15:0]            = pkt_cnt;
  end

  always_ff @(posedge aurora_clk_i) begin
    if (rst_i) state <= S_IDLE;
    else       state <= next_state;
  end

  always_comb begin
    next_state = state;
    tx_valid_o = 1'b0;
    tx_data_o  = '0;
    tx_last_o  = 1'b0;
    adc_end_o  = 1'b0;
    load       = 1'b0;
    case (state)
      S_IDLE: if (rise) next_state = S_HEAD;
      S_HEAD: begin
        tx_valid_o = 1'b1;
        tx_data_o  = hdr_word;
        if (tx_ready_i) next_state = S_DATA;
      end
      S_DATA: begin
        tx_valid_o = hold_v;
        tx_data_o  = hold;
        tx_last_o  = hold_v & pkt_done;
        // The holding register refills in the same cycle it is drained.
        load       = adc_valid_i & (~hold_v | tx_ready_i);
        if (!adc_start_i) next_state = S_DRAIN;
      end
      S_DRAIN: begin
        tx_valid_o = hold_v;
        tx_data_o  = hold;
        tx_last_o  = hold_v & pkt_done;
        if (!hold_v) next_state = (word_cnt == '0) ? S_TAIL : S_PAD;
      end
      S_PAD: begin
        tx_valid_o = 1'b1;
        tx_data_o  = PAD_WORD;
        tx_last_o  = pkt_done;
        if (tx_ready_i && pkt_done) next_state = S_TAIL;
      end
      S_TAIL: begin
        tx_valid_o = 1'b1;
        tx_data_o  = tail_word;
        tx_last_o  = 1'b1;
        if (tx_ready_i) next_state = S_END;
      end
      S_END: begin
        adc_end_o = 1'b1;
        if (end_cnt == END_LAST) next_state = S_IDLE;
      end
      default: next_state = S_IDLE;
    endcase
  end

  always_ff @(posedge aurora_clk_i) begin
    if (rst_i) begin
      start_d  <= 1'b0;
      hold     <= '0;
      hold_v   <= 1'b0;
      word_cnt <= '0;
      pkt_cnt  <= '0;
      scan_id  <= '0;
      end_cnt  <= '0;
    end else begin
      start_d <= adc_start_i;

      if (load) begin
        hold   <= adc_data_i;
        hold_v <= 1'b1;
      end else if (hs && (state == S_DATA || state == S_DRAIN)) begin
        hold_v <= 1'b0;
      end

      if (state == S_HEAD && hs) begin
        word_cnt <= '0;
        pkt_cnt  <= '0;
      end else if (hs && (state == S_DATA || state == S_DRAIN || state == S_PAD)) begin
        if (pkt_done) begin
          word_cnt <= '0;
          pkt_cnt  <= pkt_cnt + 16'd1;
        end else begin
          word_cnt <= word_cnt + 16'd1;
        end
      end

      if (state == S_TAIL && hs) scan_id <= scan_id + 16'd1;

      if (state == S_END) end_cnt <= end_cnt + 4'd1;
      else                end_cnt <= '0;
    end
  end

`ifdef SCAN_DROP_CNT_EN
  logic [15:0] drop_cnt;
  logic        drop;

  // Only DATA can drop; DRAIN ignores samples outright.
  assign drop = (state == S_DATA) & adc_valid_i & ~load;

  always_ff @(posedge aurora_clk_i) begin
    if (rst_i)                           drop_cnt <= '0;
    else if (state == S_HEAD && hs)      drop_cnt <= '0;
    else if (drop && drop_cnt != 16'hFFFF) drop_cnt <= drop_cnt + 16'd1;
  end

  assign drop_cnt_o = drop_cnt;
`else
  assign drop_cnt_o = '0;
`endif

  assign scan_active_o = (state != S_IDLE) && (state != S_END);
  assign scan_id_o     = scan_id;

endmodule

// File: tb/tb_aurora_scan_session_ctrl.sv
module tb_aurora_scan_session_ctrl;

  localparam logic [31:0] PADW = 32'hCAFE_F00D;

  logic        clk = 1'b0;
  logic        rst;
  logic        adc_start;
  logic [31:0] adc_data;
  logic        adc_valid;
  logic [31:0] tx_data;
  logic        tx_valid;
  logic        tx_ready;
  logic        tx_last;
  logic        adc_end;
  logic        scan_active;
  logic [15:0] scan_id;
  logic [15:0] drop_cnt;

  int n_cmp = 0;
  int n_err = 0;
  int end_cycles = 0;
  logic [31:0] mon_d[$];
  logic        mon_l[$];

  always #5 clk = ~clk;

  aurora_scan_session_ctrl #(
    .TCQ(0.1), .DATA_W(32), .PKT_LEN(4), .PAD_WORD(PADW), .END_PULSE_CYC(4)
  ) dut (
    .aurora_clk_i (clk),
    .rst_i        (rst),
    .adc_start_i  (adc_start),
    .adc_data_i   (adc_data),
    .adc_valid_i  (adc_valid),
    .tx_data_o    (tx_data),
    .tx_valid_o   (tx_valid),
    .tx_ready_i   (tx_ready),
    .tx_last_o    (tx_last),
    .adc_end_o    (adc_end),
    .scan_active_o(scan_active),
    .scan_id_o    (scan_id),
    .drop_cnt_o   (drop_cnt)
  );

  // Stream and end-pulse monitor, sampled away from the active edge.
  always @(negedge clk) begin
    if (rst === 1'b0) begin
      if (tx_valid && tx_ready) begin
        mon_d.push_back(tx_data);
        mon_l.push_back(tx_last);
      end
      if (adc_end) end_cycles = end_cycles + 1;
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_done(input string name);
    bit done = 0;
    for (int i = 0; i < 200 && !done; i++) begin
      if (end_cycles > 0 && !scan_active && !adc_end) done = 1;
      else tick();
    end
    n_cmp++;
    if (!done) begin
      n_err++;
      $display("FAIL %s_timeout: scan did not complete within 200 cycles (end_cycles=%0d)", name, end_cycles);
    end
  endtask

  task automatic run_scan(input int n, input logic [31:0] base);
    adc_start = 1'b1;
    tick();
    tick();
    for (int i = 0; i < n; i++) begin
      adc_valid = 1'b1;
      adc_data  = base + 32'(i);
      if (i == n - 1) adc_start = 1'b0;
      tick();
    end
    adc_valid = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1; adc_start = 1'b0; adc_valid = 1'b0; adc_data = '0; tx_ready = 1'b1;
    tick(); tick();
    n_cmp++;
    if ({tx_data, tx_valid, tx_last, adc_end, scan_active} !== 36'd0) begin
      n_err++;
      $display("FAIL reset_outputs: got data=%h v=%b l=%b end=%b act=%b, expected all 0",
               tx_data, tx_valid, tx_last, adc_end, scan_active);
    end
    n_cmp++;
    if (scan_id !== 16'd0 || drop_cnt !== 16'd0) begin
      n_err++;
      $display("FAIL reset_counters: got id=%h drop=%h, expected 0/0", scan_id, drop_cnt);
    end
    rst = 1'b0;
    tick();
  endtask

  task automatic test_exact_packet();
    logic [31:0] exp_d[$];
    logic        exp_l[$];
    mon_d.delete(); mon_l.delete(); end_cycles = 0;
    run_scan(8, 32'h1000_0000);
    wait_done("exact");
    exp_d.push_back(32'hA500_0000); exp_l.push_back(1'b0);
    for (int i = 0; i < 8; i++) begin
      exp_d.push_back(32'h1000_0000 + 32'(i)); exp_l.push_back(i % 4 == 3);
    end
    exp_d.push_back(32'h5A00_0002); exp_l.push_back(1'b1);
    n_cmp++;
    if (mon_d.size() != exp_d.size()) begin
      n_err++;
      $display("FAIL exact_len: got %0d words, expected %0d", mon_d.size(), exp_d.size());
    end
    for (int i = 0; i < exp_d.size() && i < mon_d.size(); i++) begin
      n_cmp++;
      if (mon_d[i] !== exp_d[i] || mon_l[i] !== exp_l[i]) begin
        n_err++;
        $display("FAIL exact_word%0d: got %h last=%b, expected %h last=%b",
                 i, mon_d[i], mon_l[i], exp_d[i], exp_l[i]);
      end
    end
    n_cmp++;
    if (end_cycles != 4) begin
      n_err++;
      $display("FAIL exact_end_len: got %0d cycles, expected 4", end_cycles);
    end
    n_cmp++;
    if (scan_id !== 16'd1) begin
      n_err++;
      $display("FAIL exact_scan_id: got %0d, expected 1", scan_id);
    end
  endtask

  task automatic test_partial_packet();
    logic [31:0] exp_d[$];
    logic        exp_l[$];
    mon_d.delete(); mon_l.delete(); end_cycles = 0;
    run_scan(5, 32'h2000_0000);
    wait_done("partial");
    exp_d.push_back(32'hA500_0001); exp_l.push_back(1'b0);
    for (int i = 0; i < 5; i++) begin
      exp_d.push_back(32'h2000_0000 + 32'(i)); exp_l.push_back(i == 3);
    end
    exp_d.push_back(PADW); exp_l.push_back(1'b0);
    exp_d.push_back(PADW); exp_l.push_back(1'b0);
    exp_d.push_back(PADW); exp_l.push_back(1'b1);
    exp_d.push_back(32'h5A00_0002); exp_l.push_back(1'b1);
    n_cmp++;
    if (mon_d.size() != exp_d.size()) begin
      n_err++;
      $display("FAIL partial_len: got %0d words, expected %0d", mon_d.size(), exp_d.size());
    end
    for (int i = 0; i < exp_d.size() && i < mon_d.size(); i++) begin
      n_cmp++;
      if (mon_d[i] !== exp_d[i] || mon_l[i] !== exp_l[i]) begin
        n_err++;
        $display("FAIL partial_word%0d: got %h last=%b, expected %h last=%b",
                 i, mon_d[i], mon_l[i], exp_d[i], exp_l[i]);
      end
    end
    n_cmp++;
    if (scan_id !== 16'd2) begin
      n_err++;
      $display("FAIL partial_scan_id: got %0d, expected 2", scan_id);
    end
  endtask

  task automatic test_backpressure();
    logic [31:0] exp_d[$];
    logic        exp_l[$];
    logic [15:0] exp_drop;
`ifdef SCAN_DROP_CNT_EN
    exp_drop = 16'd2;
`else
    exp_drop = 16'd0;
`endif
    mon_d.delete(); mon_l.delete(); end_cycles = 0;
    adc_start = 1'b1;
    tick(); tick();
    tx_ready = 1'b0; adc_valid = 1'b1;
    for (int i = 0; i < 3; i++) begin
      adc_data = 32'h3000_0000 + 32'(i);
      tick();
      n_cmp++;
      if (tx_valid !== 1'b1 || tx_data !== 32'h3000_0000 || tx_last !== 1'b0) begin
        n_err++;
        $display("FAIL bp_hold%0d: got v=%b data=%h l=%b, expected v=1 data=30000000 l=0",
                 i, tx_valid, tx_data, tx_last);
      end
    end
    tx_ready = 1'b1; adc_data = 32'h3000_0003; adc_start = 1'b0;
    tick();
    adc_valid = 1'b0;
    wait_done("bp");
    exp_d.push_back(32'hA500_0002); exp_l.push_back(1'b0);
    exp_d.push_back(32'h3000_0000); exp_l.push_back(1'b0);
    exp_d.push_back(32'h3000_0003); exp_l.push_back(1'b0);
    exp_d.push_back(PADW);          exp_l.push_back(1'b0);
    exp_d.push_back(PADW);          exp_l.push_back(1'b1);
    exp_d.push_back(32'h5A00_0001); exp_l.push_back(1'b1);
    n_cmp++;
    if (mon_d.size() != exp_d.size()) begin
      n_err++;
      $display("FAIL bp_len: got %0d words, expected %0d", mon_d.size(), exp_d.size());
    end
    for (int i = 0; i < exp_d.size() && i < mon_d.size(); i++) begin
      n_cmp++;
      if (mon_d[i] !== exp_d[i] || mon_l[i] !== exp_l[i]) begin
        n_err++;
        $display("FAIL bp_word%0d: got %h last=%b, expected %h last=%b",
                 i, mon_d[i], mon_l[i], exp_d[i], exp_l[i]);
      end
    end
    n_cmp++;
    if (drop_cnt !== exp_drop) begin
      n_err++;
      $display("FAIL bp_drop_cnt: got %0d, expected %0d", drop_cnt, exp_drop);
    end
  endtask

  task automatic test_empty_scan();
    mon_d.delete(); mon_l.delete(); end_cycles = 0;
    adc_start = 1'b1;
    tick();
    adc_start = 1'b0;
    n_cmp++;
    if (tx_valid !== 1'b1 || tx_data !== 32'hA500_0003 || scan_active !== 1'b1) begin
      n_err++;
      $display("FAIL empty_start_latency: got v=%b data=%h act=%b, expected v=1 data=a5000003 act=1",
               tx_valid, tx_data, scan_active);
    end
    wait_done("empty");
    n_cmp++;
    if (mon_d.size() != 2) begin
      n_err++;
      $display("FAIL empty_len: got %0d words, expected 2", mon_d.size());
    end else begin
      n_cmp++;
      if (mon_d[0] !== 32'hA500_0003 || mon_l[0] !== 1'b0 ||
          mon_d[1] !== 32'h5A00_0000 || mon_l[1] !== 1'b1) begin
        n_err++;
        $display("FAIL empty_words: got %h/%b %h/%b, expected a5000003/0 5a000000/1",
                 mon_d[0], mon_l[0], mon_d[1], mon_l[1]);
      end
    end
    n_cmp++;
    if (end_cycles != 4 || scan_id !== 16'd4 || drop_cnt !== 16'd0) begin
      n_err++;
      $display("FAIL empty_status: got end=%0d id=%0d drop=%0d, expected 4/4/0",
               end_cycles, scan_id, drop_cnt);
    end
  endtask

  task automatic test_reset_mid_data();
    adc_start = 1'b1;
    tick(); tick();
    adc_valid = 1'b1;
    adc_data = 32'h4000_0000; tick();
    adc_data = 32'h4000_0001; tick();
    rst = 1'b1; adc_start = 1'b0; adc_valid = 1'b0;
    tick();
    n_cmp++;
    if ({tx_data, tx_valid, tx_last, adc_end, scan_active} !== 36'd0 ||
        scan_id !== 16'd0 || drop_cnt !== 16'd0) begin
      n_err++;
      $display("FAIL rstmid_outputs: got data=%h v=%b l=%b end=%b act=%b id=%0d drop=%0d, expected all 0",
               tx_data, tx_valid, tx_last, adc_end, scan_active, scan_id, drop_cnt);
    end
    rst = 1'b0; end_cycles = 0;
    for (int i = 0; i < 12; i++) tick();
    n_cmp++;
    if (end_cycles != 0 || scan_active !== 1'b0) begin
      n_err++;
      $display("FAIL rstmid_no_end: got end=%0d act=%b, expected 0/0", end_cycles, scan_active);
    end
  endtask

  task automatic test_held_start();
    int bad = 0;
    end_cycles = 0;
    adc_start = 1'b1;
    tick();
    adc_start = 1'b0;
    tick(); tick();
    adc_start = 1'b1;
    wait_done("held");
    for (int i = 0; i < 20; i++) begin
      tick();
      if (scan_active !== 1'b0 || tx_valid !== 1'b0) bad++;
    end
    n_cmp++;
    if (bad != 0) begin
      n_err++;
      $display("FAIL held_stays_idle: got %0d active cycles, expected 0", bad);
    end
    adc_start = 1'b0;
    tick();
    adc_start = 1'b1;
    tick();
    n_cmp++;
    if (tx_valid !== 1'b1 || tx_data !== 32'hA500_0001) begin
      n_err++;
      $display("FAIL held_restart: got v=%b data=%h, expected v=1 data=a5000001", tx_valid, tx_data);
    end
    adc_start = 1'b0; end_cycles = 0;
    wait_done("held_restart");
  endtask

  initial begin
    test_reset();
    test_exact_packet();
    test_partial_packet();
    test_backpressure();
    test_empty_scan();
    test_reset_mid_data();
    test_held_start();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
